// File: rtl/otter_pkg.sv
// otter_pkg: types and constants shared by the OTTER pipeline hazard logic.
//   opcode_t  - RV32I major opcodes (instruction bits [6:0])
//   fwd_sel_t - EX operand bypass source encoding
//   tag_t     - in-flight producer tag {valid, rd, is_load}
//   NOP       - canonical bubble instruction (addi x0,x0,0)
package otter_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } tag_t;

  localparam tag_t        TAG_NONE = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};
  localparam logic [31:0] NOP      = 32'h00000013;

  // A source only hits a tag when the consumer really reads it (live)
  // and the tag names a real producer of that register.
  function automatic logic tag_hit(input tag_t t, input logic [4:0] src, input logic live);
    return live && t.valid && (t.rd == src);
  endfunction

endpackage

// File: rtl/src_use_decode.sv
// src_use_decode: classifies an opcode by which register fields it uses.
//   opcode    in  7  instruction bits [6:0]
//   uses_rs1  out 1  instruction reads rs1
//   uses_rs2  out 1  instruction reads rs2
//   writes_rd out 1  instruction writes rd (rd=x0 filtering is left to the caller)
//   is_load   out 1  instruction is a load (result only available after MEM)
module src_use_decode
  import otter_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_load
);

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      LUI, AUIPC, JAL: writes_rd = 1'b1;
      JALR: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      BRANCH, STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      LOAD: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OP_IMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      SYSTEM:  uses_rs1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding select generation and load-use interlock for
// the 5-stage OTTER pipeline. Tracks producers in a private EX/MEM/WB tag
// pipeline and compares them against the instruction in ID.
//   clk, rst           clock, synchronous active-high reset
//   dec_ir, dec_valid  instruction in ID and its valid flag
//   flush              taken branch/jump in EX, kills the ID instruction
//   rs1_fwd_sel        registered EX operand A source (00 RF, 01 MEM, 10 WB)
//   rs2_fwd_sel        registered EX operand B source
//   pc_write, reg_en   PC / IF-ID enables (low while stalling)
//   clear              bubble into ID/EX (stall or flush)
//   stall              interlock active this cycle
//   stall_cycles       saturating stall-cycle counter (CNT_W bits)
// Build option: define FWD_WB_EN to enable forwarding from WB (select 10).
// Without it a MEM-stage producer stalls one cycle and the register file
// supplies the value afterwards.
module fwd_hazard_unit
  import otter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      dec_ir,
  input  logic             dec_valid,
  input  logic             flush,
  output logic [1:0]       rs1_fwd_sel,
  output logic [1:0]       rs2_fwd_sel,
  output logic             pc_write,
  output logic             reg_en,
  output logic             clear,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [4:0] rs1, rs2, rd;
  logic       uses_rs1, uses_rs2, writes_rd, dec_is_load;
  logic       rs1_live, rs2_live;
  logic       rs1_ex, rs2_ex, rs1_mem, rs2_mem;
  logic       load_use, hazard, stall_int;
  tag_t       dec_tag, ex_tag, mem_tag, wb_tag;
  fwd_sel_t   rs1_sel_q, rs2_sel_q;
  logic       unused_bits;

  assign rs1 = dec_ir[19:15];
  assign rs2 = dec_ir[24:20];
  assign rd  = dec_ir[11:7];

  src_use_decode u_src_use_decode (
    .opcode    (dec_ir[6:0]),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (dec_is_load)
  );

  // x0 and unused fields never match; bubbles never read anything.
  assign rs1_live = dec_valid && uses_rs1 && (rs1 != 5'd0);
  assign rs2_live = dec_valid && uses_rs2 && (rs2 != 5'd0);

  always_comb begin
    dec_tag         = TAG_NONE;
    dec_tag.valid   = dec_valid && writes_rd && (rd != 5'd0);
    dec_tag.rd      = rd;
    dec_tag.is_load = dec_is_load;
  end

  assign rs1_ex  = tag_hit(ex_tag,  rs1, rs1_live);
  assign rs2_ex  = tag_hit(ex_tag,  rs2, rs2_live);
  assign rs1_mem = tag_hit(mem_tag, rs1, rs1_live);
  assign rs2_mem = tag_hit(mem_tag, rs2, rs2_live);

  // A load in EX has no data yet: the consumer must wait one cycle.
  assign load_use = ex_tag.is_load && (rs1_ex || rs2_ex);

`ifdef FWD_WB_EN
  assign hazard = load_use;
`else
  // A MEM match shadowed by a nearer EX match is served by the MEM bypass,
  // so only an uncovered MEM match needs the extra cycle.
  assign hazard = load_use || (rs1_mem && !rs1_ex) || (rs2_mem && !rs2_ex);
`endif

  // Flush wins over stall: the consumer is being killed anyway.
  assign stall_int = hazard && !flush && !rst;
  assign stall     = stall_int;
  assign pc_write  = !stall_int;
  assign reg_en    = !stall_int;
  assign clear     = !rst && (flush || stall_int);

  function automatic fwd_sel_t pick_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex) return FWD_MEM;
`ifdef FWD_WB_EN
    if (hit_mem) return FWD_WB;
`else
    if (hit_mem) return FWD_RF;
`endif
    return FWD_RF;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag       <= TAG_NONE;
      mem_tag      <= TAG_NONE;
      wb_tag       <= TAG_NONE;
      rs1_sel_q    <= FWD_RF;
      rs2_sel_q    <= FWD_RF;
      stall_cycles <= '0;
    end else begin
      wb_tag  <= mem_tag;
      mem_tag <= ex_tag;
      if (stall_int || flush) begin
        ex_tag    <= TAG_NONE;
        rs1_sel_q <= FWD_RF;
        rs2_sel_q <= FWD_RF;
      end else begin
        ex_tag    <= dec_tag;
        rs1_sel_q <= pick_sel(rs1_ex, rs1_mem);
        rs2_sel_q <= pick_sel(rs2_ex, rs2_mem);
      end
      if (stall_int && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

  assign rs1_fwd_sel = rs1_sel_q;
  assign rs2_fwd_sel = rs2_sel_q;

  // WB tag is tracked for the issue logic but not consumed here.
  assign unused_bits = ^{dec_ir[31:25], dec_ir[14:12], wb_tag};

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scoreboard bench for fwd_hazard_unit.
// Each stimulus cycle pushes its hand-derived expected outputs; a monitor
// on the falling edge pops and compares them. The counter is built 2 bits
// wide so saturation is reachable. Follows the FWD_WB_EN build option.
module tb_fwd_hazard_unit;

  localparam int CW = 2;

  localparam logic [31:0] I_ADDI5  = 32'h00500293;
  localparam logic [31:0] I_ADD6   = 32'h00528333;
  localparam logic [31:0] I_LW5    = 32'h0000A283;
  localparam logic [31:0] I_ADDI0  = 32'h00100013;
  localparam logic [31:0] I_ADD600 = 32'h00000333;
  localparam logic [31:0] I_NOP    = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   dec_ir;
  logic          dec_valid;
  logic          flush;
  logic [1:0]    rs1_fwd_sel, rs2_fwd_sel;
  logic          pc_write, reg_en, clear, stall;
  logic [CW-1:0] stall_cycles;

  typedef struct {
    string         name;
    logic          stall;
    logic          pcw;
    logic          regen;
    logic          clr;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] cur_cnt = '0;

  fwd_hazard_unit #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_ir       (dec_ir),
    .dec_valid    (dec_valid),
    .flush        (flush),
    .rs1_fwd_sel  (rs1_fwd_sel),
    .rs2_fwd_sel  (rs2_fwd_sel),
    .pc_write     (pc_write),
    .reg_en       (reg_en),
    .clear        (clear),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what that cycle must show.
  task automatic applyStimulus(input string name, input logic [31:0] ir, input logic v,
                               input logic fl, input logic r, input logic es,
                               input logic [1:0] e1, input logic [1:0] e2);
    exp_t e;
    @(posedge clk);
    #1;
    dec_ir    = ir;
    dec_valid = v;
    flush     = fl;
    rst       = r;
    e.name  = name;
    e.stall = es;
    e.pcw   = !es;
    e.regen = !es;
    e.clr   = !r && (es || fl);
    e.s1    = e1;
    e.s2    = e2;
    e.cnt   = cur_cnt;
    sb.push_back(e);
    if (r) cur_cnt = '0;
    else if (es && (cur_cnt != {CW{1'b1}})) cur_cnt = cur_cnt + 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus("idle", I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic cmp(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "stall",        {7'd0, stall},        {7'd0, e.stall});
    cmp(e.name, "pc_write",     {7'd0, pc_write},     {7'd0, e.pcw});
    cmp(e.name, "reg_en",       {7'd0, reg_en},       {7'd0, e.regen});
    cmp(e.name, "clear",        {7'd0, clear},        {7'd0, e.clr});
    cmp(e.name, "rs1_fwd_sel",  {6'd0, rs1_fwd_sel},  {6'd0, e.s1});
    cmp(e.name, "rs2_fwd_sel",  {6'd0, rs2_fwd_sel},  {6'd0, e.s2});
    cmp(e.name, "stall_cycles", {6'd0, stall_cycles}, {6'd0, e.cnt});
  endtask

  // Monitor: every falling edge with pending expectations is a check point.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    rst       = 1'b1;
    dec_ir    = I_NOP;
    dec_valid = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus("reset", I_NOP, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);

    // Back-to-back ALU dependency: MEM-stage bypass on both operands.
    applyStimulus("t1_addi",   I_ADDI5, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t1_add",    I_ADD6,  1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t1_add_ex", I_NOP,   1, 0, 0, 0, 2'b01, 2'b01);
    applyStimulus("t1_nop",    I_NOP,   1, 0, 0, 0, 2'b00, 2'b00);

    // Distance-two dependency.
    applyStimulus("t2_addi", I_ADDI5, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t2_nop",  I_NOP,   1, 0, 0, 0, 2'b00, 2'b00);
`ifdef FWD_WB_EN
    applyStimulus("t2_add",    I_ADD6, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t2_add_ex", I_NOP,  1, 0, 0, 0, 2'b10, 2'b10);
    applyStimulus("t2_nop2",   I_NOP,  1, 0, 0, 0, 2'b00, 2'b00);
`else
    applyStimulus("t2_add_stall", I_ADD6, 1, 0, 0, 1, 2'b00, 2'b00);
    applyStimulus("t2_add_held",  I_ADD6, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t2_add_ex",    I_NOP,  1, 0, 0, 0, 2'b00, 2'b00);
`endif
    idle(2);

    // Load-use.
    applyStimulus("t3_lw",       I_LW5,  1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t3_lu_stall", I_ADD6, 1, 0, 0, 1, 2'b00, 2'b00);
`ifdef FWD_WB_EN
    applyStimulus("t3_add_held", I_ADD6, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t3_add_ex",   I_NOP,  1, 0, 0, 0, 2'b10, 2'b10);
    applyStimulus("t3_nop",      I_NOP,  1, 0, 0, 0, 2'b00, 2'b00);
`else
    applyStimulus("t3_stall2",   I_ADD6, 1, 0, 0, 1, 2'b00, 2'b00);
    applyStimulus("t3_add_held", I_ADD6, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t3_add_ex",   I_NOP,  1, 0, 0, 0, 2'b00, 2'b00);
`endif
    idle(2);

    // x0 never matches; an invalid consumer never stalls.
    applyStimulus("t4_addi_x0", I_ADDI0,  1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t4_add_x0",  I_ADD600, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t4_add_ex",  I_NOP,    1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t4_lw",      I_LW5,    1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t4_bubble",  I_ADD6,   0, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t4_idle",    I_NOP,    0, 0, 0, 0, 2'b00, 2'b00);
    idle(2);

    // Flush in the load-use cycle.
    applyStimulus("t5_lw",       I_LW5,  1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t5_flush",    I_ADD6, 1, 1, 0, 0, 2'b00, 2'b00);
    applyStimulus("t5_redirect", I_NOP,  1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t5_nop",      I_NOP,  1, 0, 0, 0, 2'b00, 2'b00);
    idle(2);

    // Reset in the middle of a stall.
    applyStimulus("t6_lw",    I_LW5,  1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t6_stall", I_ADD6, 1, 0, 0, 1, 2'b00, 2'b00);
    applyStimulus("t6_rst",   I_ADD6, 1, 0, 1, 0, 2'b00, 2'b00);
    applyStimulus("t6_after", I_ADD6, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("t6_nop",   I_NOP,  1, 0, 0, 0, 2'b00, 2'b00);
    idle(2);

    // Repeated load-use pairs drive the 2-bit counter into saturation.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("t7_lw",    I_LW5,  1, 0, 0, 0, 2'b00, 2'b00);
      applyStimulus("t7_stall", I_ADD6, 1, 0, 0, 1, 2'b00, 2'b00);
`ifdef FWD_WB_EN
      applyStimulus("t7_held",  I_ADD6, 1, 0, 0, 0, 2'b00, 2'b00);
      applyStimulus("t7_ex",    I_NOP,  0, 0, 0, 0, 2'b10, 2'b10);
      applyStimulus("t7_idle",  I_NOP,  0, 0, 0, 0, 2'b00, 2'b00);
`else
      applyStimulus("t7_stall2", I_ADD6, 1, 0, 0, 1, 2'b00, 2'b00);
      applyStimulus("t7_held",   I_ADD6, 1, 0, 0, 0, 2'b00, 2'b00);
      applyStimulus("t7_ex",     I_NOP,  0, 0, 0, 0, 2'b00, 2'b00);
      applyStimulus("t7_idle",   I_NOP,  0, 0, 0, 0, 2'b00, 2'b00);
`endif
    end
    applyStimulus("t7_final", I_NOP, 0, 0, 0, 0, 2'b00, 2'b00);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
